// File: rtl/neuron_mem_pkg.sv
// Shared types and helpers for the ping-pong neuron activation memory.
package neuron_mem_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 12;

    // Swap sequencer: SWAP lasts exactly one cycle.
    typedef enum logic {
        IDLE = 1'b0,
        SWAP = 1'b1
    } swap_state_e;

    // True when a neuron address falls inside a bank of the given depth.
    function automatic logic in_range(input logic [31:0] addr, input logic [31:0] depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/neuron_mem_pingpong_if.sv
// Access bus of the ping-pong memory: read port, write port and swap handshake.
interface neuron_mem_pingpong_if
    import neuron_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [DATA_W-1:0] rd_data;
    logic                     rd_valid;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic signed [DATA_W-1:0] wr_data;
    logic                     swap_req;
    logic                     swap_ack;
    logic                     busy;
    logic                     active_bank;
    logic [ADDR_W:0]          wr_count;
    logic                     addr_err;

    // Layer datapath side.
    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, swap_req,
        input  rd_data, rd_valid, swap_ack, busy, active_bank, wr_count, addr_err
    );

    // Memory side.
    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, swap_req,
        output rd_data, rd_valid, swap_ack, busy, active_bank, wr_count, addr_err
    );
endinterface

// File: rtl/neuron_bank.sv
// One activation bank: DEPTH x DATA_W RAM, one write port, one registered read port.
module neuron_bank #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [ADDR_W-1:0]        waddr_i,
    input  logic signed [DATA_W-1:0] wdata_i,
    input  logic                     re_i,
    input  logic [ADDR_W-1:0]        raddr_i,
    output logic signed [DATA_W-1:0] rdata_o
);
    // Addresses are range-checked upstream, so only the low index bits matter.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic signed [DATA_W-1:0] mem_q [DEPTH];
    logic signed [DATA_W-1:0] rdata_q;

    // RAM write and registered read; the read register holds when re_i is low.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i[IDX_W-1:0]] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i[IDX_W-1:0]];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/neuron_mem_pingpong.sv
// Double-buffered neuron activation memory: one bank is read by the current
// layer while the other collects the next layer's outputs; a swap exchanges them.
// DEPTH must not exceed 2**ADDR_W.
module neuron_mem_pingpong
    import neuron_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    neuron_mem_pingpong_if.slave bus
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    swap_state_e              state_q, state_d;
    logic                     active_q, active_d;
    logic [ADDR_W:0]          wr_count_q, wr_count_d;
    logic                     swap_ack_q, swap_ack_d;
    logic                     addr_err_q, addr_err_d;
    logic                     rd_valid_q;
    logic                     rd_sel_q;
    logic                     rd_zero_q;

    logic                     busy;
    logic                     rd_acc, rd_ok;
    logic                     wr_acc, wr_ok;
    logic [1:0]               bank_we, bank_re;
    logic signed [DATA_W-1:0] bank_rdata [2];

    // Accesses are only honoured outside the swap cycle.
    assign busy   = (state_q == SWAP);
    assign rd_acc = bus.rd_en && !busy;
    assign wr_acc = bus.wr_en && !busy;
    assign rd_ok  = rd_acc && in_range(32'(bus.rd_addr), 32'(DEPTH));
    assign wr_ok  = wr_acc && in_range(32'(bus.wr_addr), 32'(DEPTH));

    // Reads go to the active bank, writes to the other one.
    assign bank_re = rd_ok ? (active_q ? 2'b10 : 2'b01) : 2'b00;
    assign bank_we = wr_ok ? (active_q ? 2'b01 : 2'b10) : 2'b00;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        neuron_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_bank (
            .clk     (clk),
            .we_i    (bank_we[b]),
            .waddr_i (bus.wr_addr),
            .wdata_i (bus.wr_data),
            .re_i    (bank_re[b]),
            .raddr_i (bus.rd_addr),
            .rdata_o (bank_rdata[b])
        );
    end

    // Swap sequencer next state, write counter and error flag.
    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        wr_count_d = wr_count_q;
        swap_ack_d = 1'b0;
        addr_err_d = (rd_acc && !rd_ok) || (wr_acc && !wr_ok);
        case (state_q)
            IDLE: begin
                // A write coinciding with swap_req is counted before the clear.
                if (wr_ok && (wr_count_q != DEPTH_C)) begin
                    wr_count_d = wr_count_q + 1'b1;
                end
                if (bus.swap_req) begin
                    state_d = SWAP;
                end
            end
            SWAP: begin
                state_d    = IDLE;
                active_d   = ~active_q;
                wr_count_d = '0;
                swap_ack_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state registers; a reset during SWAP aborts it without an ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            active_q   <= 1'b0;
            wr_count_q <= '0;
            swap_ack_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            wr_count_q <= wr_count_d;
            swap_ack_q <= swap_ack_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Read tracking: which bank answered, and whether the answer is forced to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_sel_q   <= 1'b0;
            rd_zero_q  <= 1'b1;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_sel_q  <= active_q;
                rd_zero_q <= !rd_ok;
            end
        end
    end

    assign bus.rd_data     = rd_zero_q ? '0 : bank_rdata[rd_sel_q];
    assign bus.rd_valid    = rd_valid_q;
    assign bus.swap_ack    = swap_ack_q;
    assign bus.busy        = busy;
    assign bus.active_bank = active_q;
    assign bus.wr_count    = wr_count_q;
    assign bus.addr_err    = addr_err_q;

endmodule

// File: tb/tb_neuron_mem_pingpong.sv
// Self-checking bench for neuron_mem_pingpong: a DEPTH=3000 instance for the
// main scenarios and a DEPTH=4 instance for counter saturation.
module tb_neuron_mem_pingpong;
    import neuron_mem_pkg::*;

    localparam int DW      = 16;
    localparam int AW      = 12;
    localparam int DEPTH_A = 3000;
    localparam int DEPTH_B = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    neuron_mem_pingpong_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    neuron_mem_pingpong_if #(.DATA_W(DW), .ADDR_W(AW)) bus_s ();

    neuron_mem_pingpong #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH_A)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    neuron_mem_pingpong #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH_B)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t sbq[$];

    // Reference model of the two banks and the read-bank index.
    logic [DW-1:0] mdl [2][DEPTH_A];
    int            mact = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every rd_valid must match the oldest outstanding read, one cycle after issue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                checks++;
                errors++;
                $display("FAIL rd_missing: no rd_valid in cycle %0d, expected data %h", e.cyc, e.data);
            end
            if (bus.rd_valid === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected: rd_valid=1 data=%h with no read outstanding", bus.rd_data);
                end else begin
                    e = sbq.pop_front();
                    if (bus.rd_data !== e.data || cyc !== e.cyc) begin
                        errors++;
                        $display("FAIL rd_data: got %h in cycle %0d, expected %h in cycle %0d",
                                 bus.rd_data, cyc, e.data, e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rd_en = 1'b0;   bus.rd_addr = '0;  bus.wr_en = 1'b0;
        bus.wr_addr = '0;   bus.wr_data = '0;  bus.swap_req = 1'b0;
        bus_s.rd_en = 1'b0; bus_s.rd_addr = '0; bus_s.wr_en = 1'b0;
        bus_s.wr_addr = '0; bus_s.wr_data = '0; bus_s.swap_req = 1'b0;
    endtask

    // One in-IDLE write on the main instance, mirrored into the model.
    task automatic do_write(input int addr, input logic [DW-1:0] data);
        bus.wr_en = 1'b1; bus.wr_addr = AW'(addr); bus.wr_data = data;
        if (addr < DEPTH_A) mdl[1 - mact][addr] = data;
        tick();
        bus.wr_en = 1'b0;
    endtask

    // One in-IDLE read on the main instance; the expected result goes to the scoreboard.
    task automatic do_read(input int addr);
        exp_t e;
        e.data = (addr < DEPTH_A) ? mdl[mact][addr] : '0;
        e.cyc  = cyc + 1;
        sbq.push_back(e);
        bus.rd_en = 1'b1; bus.rd_addr = AW'(addr);
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic do_swap();
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        tick();
        mact = 1 - mact;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.rd_valid, bus.swap_ack, bus.busy, bus.active_bank, bus.addr_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.rd_valid, bus.swap_ack, bus.busy, bus.active_bank, bus.addr_err});
        end
        checks++;
        if (bus.rd_data !== 16'h0000) begin
            errors++; $display("FAIL reset_rd_data: got %h expected 0000", bus.rd_data);
        end
        checks++;
        if (bus.wr_count !== 13'd0) begin
            errors++; $display("FAIL reset_wr_count: got %0d expected 0", bus.wr_count);
        end
        checks++;
        if ({bus_s.busy, bus_s.active_bank, bus_s.wr_count} !== 15'd0) begin
            errors++; $display("FAIL reset_small: got busy=%b active=%b count=%0d expected 0",
                               bus_s.busy, bus_s.active_bank, bus_s.wr_count);
        end
        rst = 1'b0;
        mact = 0;
        tick();
    endtask

    task automatic test_fill_swap();
        logic [DW-1:0] vals [4];
        vals = '{16'h0007, 16'h0005, 16'h0009, 16'h0004};
        for (int i = 0; i < 4; i++) do_write(i, vals[i]);
        checks++;
        if (bus.wr_count !== 13'd4) begin
            errors++; $display("FAIL fill_wr_count: got %0d expected 4", bus.wr_count);
        end
        bus.swap_req = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.swap_ack !== 1'b0) begin
            errors++; $display("FAIL swap_busy: got busy=%b ack=%b expected busy=1 ack=0", bus.busy, bus.swap_ack);
        end
        bus.swap_req = 1'b0;
        tick();
        mact = 1;
        checks++;
        if (bus.swap_ack !== 1'b1 || bus.active_bank !== 1'b1 || bus.wr_count !== 13'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL swap_done: got ack=%b active=%b count=%0d busy=%b expected 1 1 0 0",
                     bus.swap_ack, bus.active_bank, bus.wr_count, bus.busy);
        end
        for (int i = 0; i < 4; i++) do_read(i);
        checks++;
        if (bus.swap_ack !== 1'b0) begin
            errors++; $display("FAIL swap_ack_pulse: got %b expected 0", bus.swap_ack);
        end
        tick();
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== 16'h0004) begin
            errors++; $display("FAIL rd_hold: got valid=%b data=%h expected 0 0004", bus.rd_valid, bus.rd_data);
        end
    endtask

    task automatic test_swap_collision();
        exp_t e;
        do_write(6, 16'h0BAD);
        // Cycle N: swap request, write 5, read 0 from the old read bank.
        e.data = mdl[mact][0];
        e.cyc  = cyc + 1;
        sbq.push_back(e);
        bus.swap_req = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = 12'd5; bus.wr_data = 16'h1234;
        bus.rd_en = 1'b1; bus.rd_addr = 12'd0;
        mdl[1 - mact][5] = 16'h1234;
        tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.wr_count !== 13'd2) begin
            errors++; $display("FAIL coll_busy: got busy=%b count=%0d expected 1 2", bus.busy, bus.wr_count);
        end
        // Cycle N+1: everything here must be dropped.
        bus.wr_addr = 12'd6; bus.wr_data = 16'h5678;
        bus.rd_addr = 12'd1;
        tick();
        idle_inputs();
        mact = 1 - mact;
        checks++;
        if (bus.swap_ack !== 1'b1 || bus.active_bank !== 1'b0 || bus.wr_count !== 13'd0) begin
            errors++; $display("FAIL coll_swap: got ack=%b active=%b count=%0d expected 1 0 0",
                               bus.swap_ack, bus.active_bank, bus.wr_count);
        end
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.addr_err !== 1'b0) begin
            errors++; $display("FAIL coll_drop: got valid=%b err=%b expected 0 0", bus.rd_valid, bus.addr_err);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.active_bank !== 1'b0) begin
            errors++; $display("FAIL coll_no_reswap: got busy=%b active=%b expected 0 0", bus.busy, bus.active_bank);
        end
        do_read(5);
        do_read(6);
        tick();
    endtask

    task automatic test_back_to_back();
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        tick();
        checks++;
        if (bus.swap_ack !== 1'b1 || bus.active_bank !== 1'b1) begin
            errors++; $display("FAIL b2b_first: got ack=%b active=%b expected 1 1", bus.swap_ack, bus.active_bank);
        end
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.swap_ack !== 1'b0) begin
            errors++; $display("FAIL b2b_accept: got busy=%b ack=%b expected 1 0", bus.busy, bus.swap_ack);
        end
        tick();
        checks++;
        if (bus.swap_ack !== 1'b1 || bus.active_bank !== 1'b0) begin
            errors++; $display("FAIL b2b_second: got ack=%b active=%b expected 1 0", bus.swap_ack, bus.active_bank);
        end
        do_read(5);
        tick();
    endtask

    task automatic test_out_of_range();
        exp_t e;
        logic [AW:0] wc;
        e.data = '0;
        e.cyc  = cyc + 1;
        sbq.push_back(e);
        bus.rd_en = 1'b1; bus.rd_addr = 12'd3000;
        tick();
        bus.rd_en = 1'b0;
        checks++;
        if (bus.addr_err !== 1'b1) begin
            errors++; $display("FAIL oob_rd_err: got %b expected 1", bus.addr_err);
        end
        tick();
        checks++;
        if (bus.addr_err !== 1'b0) begin
            errors++; $display("FAIL oob_rd_pulse: got %b expected 0", bus.addr_err);
        end
        do_write(2, 16'h00AA);
        wc = bus.wr_count;
        bus.wr_en = 1'b1; bus.wr_addr = 12'd4095; bus.wr_data = 16'h7777;
        tick();
        bus.wr_en = 1'b0;
        checks++;
        if (bus.addr_err !== 1'b1 || bus.wr_count !== wc || wc !== 13'd1) begin
            errors++; $display("FAIL oob_wr: got err=%b count=%0d expected 1 1", bus.addr_err, bus.wr_count);
        end
        tick();
        checks++;
        if (bus.addr_err !== 1'b0) begin
            errors++; $display("FAIL oob_wr_pulse: got %b expected 0", bus.addr_err);
        end
    endtask

    task automatic test_reset_mid_swap();
        do_swap();
        bus.swap_req = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL mid_busy: got %b expected 1", bus.busy);
        end
        bus.swap_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mact = 0;
        checks++;
        if (bus.active_bank !== 1'b0 || bus.swap_ack !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got active=%b ack=%b busy=%b expected 0 0 0",
                               bus.active_bank, bus.swap_ack, bus.busy);
        end
        tick();
        checks++;
        if (bus.swap_ack !== 1'b0 || bus.active_bank !== 1'b0) begin
            errors++; $display("FAIL mid_no_ack: got ack=%b active=%b expected 0 0", bus.swap_ack, bus.active_bank);
        end
        // RAM contents survive reset.
        do_read(5);
        tick();
    endtask

    task automatic test_signed_saturation();
        int            wa [6];
        logic [DW-1:0] wd [6];
        int            ra [4];
        logic [DW-1:0] rexp [4];
        wa = '{0, 1, 2, 3, 1, 2};
        wd = '{16'hFFF9, 16'h8000, 16'h7FFF, 16'h0001, 16'h1111, 16'h2222};
        ra = '{0, 1, 2, 3};
        rexp = '{16'hFFF9, 16'h1111, 16'h2222, 16'h0001};
        for (int i = 0; i < 6; i++) begin
            bus_s.wr_en = 1'b1; bus_s.wr_addr = AW'(wa[i]); bus_s.wr_data = wd[i];
            tick();
            if (i == 3) begin
                checks++;
                if (bus_s.wr_count !== 13'd4) begin
                    errors++; $display("FAIL sat_count4: got %0d expected 4", bus_s.wr_count);
                end
            end
        end
        bus_s.wr_en = 1'b0;
        checks++;
        if (bus_s.wr_count !== 13'd4) begin
            errors++; $display("FAIL sat_count6: got %0d expected 4", bus_s.wr_count);
        end
        bus_s.swap_req = 1'b1;
        tick();
        bus_s.swap_req = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus_s.rd_en = 1'b1; bus_s.rd_addr = AW'(ra[i]);
            tick();
            checks++;
            if (bus_s.rd_valid !== 1'b1 || bus_s.rd_data !== rexp[i]) begin
                errors++; $display("FAIL sat_read%0d: got valid=%b data=%h expected 1 %h",
                                   i, bus_s.rd_valid, bus_s.rd_data, rexp[i]);
            end
            if (i == 0) begin
                checks++;
                if ($signed(bus_s.rd_data) != -16'sd7) begin
                    errors++; $display("FAIL signed_value: got %0d expected -7", $signed(bus_s.rd_data));
                end
            end
        end
        bus_s.rd_en = 1'b0;
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fill_swap();
        test_swap_collision();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_swap();
        test_signed_saturation();
        tick();
        tick();
        checks++;
        if (sbq.size() != 0) begin
            errors++; $display("FAIL sb_drain: %0d reads still outstanding, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
